// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed 7-segment display driver.
// Segment codes are active-high, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-high 7-segment decoder.
// Illegal BCD codes (10..15) show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit common-anode 7-segment scanner: prescaler, digit index,
// per-frame input snapshot, leading-zero blanking and registered pin drive.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int REFRESH_BITS   = 18,
  parameter int GUARD          = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] bcd_0,
  input  logic [3:0] bcd_1,
  input  logic [3:0] bcd_2,
  input  logic [3:0] bcd_3,
  input  logic [3:0] dp_in,
  input  logic       lz_blank,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam logic [REFRESH_BITS-1:0] GUARD_C = GUARD[REFRESH_BITS-1:0];

  localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW  ? 4'hF : 4'h0;
  localparam logic [6:0] SEG_IDL = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_IDL  = SEG_ACTIVE_LOW;

  logic [REFRESH_BITS-1:0]           cnt;
  digit_idx_t                        idx;
  logic                              tick;
  logic [NUM_DIGITS-1:0][3:0]        snap_bcd;
  logic [NUM_DIGITS-1:0]             snap_dp;
  logic                              snap_lz;
  logic [NUM_DIGITS-1:0]             blank;
  logic [3:0]                        digit;
  logic [6:0]                        seg_raw;
  logic [6:0]                        seg_next;
  logic [3:0]                        an_next;
  logic                              dp_next;
  logic [3:0]                        an_p1;
  logic [6:0]                        seg_p1;
  logic                              dp_p1;

  assign tick = enable && (cnt == '1);

  // Scan state: prescaler, digit index and the once-per-frame snapshot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      idx      <= '0;
      snap_bcd <= '0;
      snap_dp  <= '0;
      snap_lz  <= 1'b0;
    end else begin
      if (enable) cnt <= cnt + 1'b1;
      if (tick) idx <= idx + 2'd1;
      if (tick && idx == 2'd3) begin
        snap_bcd <= {bcd_3, bcd_2, bcd_1, bcd_0};
        snap_dp  <= dp_in;
        snap_lz  <= lz_blank;
      end
    end
  end

  // Blanking cascades from the leftmost digit; the units digit always shows.
  always_comb begin
    blank    = '0;
    blank[3] = snap_lz && (snap_bcd[3] == 4'd0);
    blank[2] = blank[3] && (snap_bcd[2] == 4'd0);
    blank[1] = blank[2] && (snap_bcd[1] == 4'd0);
  end

  assign digit = snap_bcd[idx];

  bcd_to_seg7 u_dec (
    .bcd (digit),
    .seg (seg_raw)
  );

  always_comb begin
    an_next  = '0;
    seg_next = blank[idx] ? SEG_OFF : seg_raw;
    dp_next  = snap_dp[idx];
    if (enable && cnt >= GUARD_C) an_next[idx] = 1'b1;
  end

  // Output stage: one register between scan state and the pins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_p1  <= AN_OFF;
      seg_p1 <= SEG_IDL;
      dp_p1  <= DP_IDL;
    end else begin
      an_p1  <= an_next ^ {4{AN_ACTIVE_LOW}};
      seg_p1 <= seg_next ^ {7{SEG_ACTIVE_LOW}};
      dp_p1  <= dp_next ^ SEG_ACTIVE_LOW;
    end
  end

  assign an  = an_p1;
  assign seg = seg_p1;
  assign dp  = dp_p1;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with an 8-cycle slot (REFRESH_BITS=3) and GUARD=1.
// Edge k means the k-th rising clock edge after reset release; outputs are sampled on the following falling edge.
module tb_seg7_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] bcd_0, bcd_1, bcd_2, bcd_3;
  logic [3:0] dp_in;
  logic       lz_blank;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int unsigned ecnt;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          lit;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  seg7_scan #(
    .REFRESH_BITS   (3),
    .GUARD          (1),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .bcd_0    (bcd_0),
    .bcd_1    (bcd_1),
    .bcd_2    (bcd_2),
    .bcd_3    (bcd_3),
    .dp_in    (dp_in),
    .lz_blank (lz_blank),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic wait_edge(input int unsigned k);
    for (int g = 0; g < 200 && ecnt < k; g++) @(negedge clk);
    if (ecnt != k) check("edge_sync", ecnt, k);
  endtask

  task automatic check_pins(input string tag, input logic [3:0] a, input logic [6:0] s, input logic d);
    check({tag, "_an"}, an, a);
    check({tag, "_seg"}, seg, s);
    check({tag, "_dp"}, dp, d);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; lz_blank = 1'b0; dp_in = 4'h0;
    bcd_3 = 4'd1; bcd_2 = 4'd2; bcd_1 = 4'd3; bcd_0 = 4'd4;
    repeat (3) @(negedge clk);
    check_pins("in_reset", 4'hF, 7'h7F, 1'b1);
    reset = 1'b1;
    #1 check_pins("released", 4'hF, 7'h7F, 1'b1);

    // Frame 1 still shows the zero snapshot
    wait_edge(1);  check_pins("e1_guard", 4'hF, 7'h40, 1'b1);
    wait_edge(2);  check_pins("e2_d0", 4'hE, 7'h40, 1'b1);
    wait_edge(10); check_pins("f1_d1", 4'hD, 7'h40, 1'b1);

    lit = 0;
    for (int k = 33; k <= 40; k++) begin
      wait_edge(k);
      if (an == 4'hE) lit++;
      if (k == 34) check("f2_d0_seg", seg, 7'h19);
      if (k == 36) bcd_0 = 4'd9;
      if (k == 38) check("d0_no_midframe", seg, 7'h19);
    end
    check("d0_lit_cycles", lit, 7);

    wait_edge(41); check_pins("d1_guard", 4'hF, 7'h30, 1'b1);
    wait_edge(42); check_pins("f2_d1", 4'hD, 7'h30, 1'b1);
    wait_edge(50); check_pins("f2_d2", 4'hB, 7'h24, 1'b1);
    wait_edge(58); check_pins("f2_d3", 4'h7, 7'h79, 1'b1);
    wait_edge(66); check_pins("f3_d0_new", 4'hE, 7'h10, 1'b1);

    // Mid-slot reset, then leading-zero blanking
    wait_edge(70);
    reset = 1'b0;
    #1 check_pins("midslot_reset", 4'hF, 7'h7F, 1'b1);
    bcd_3 = 4'd0; bcd_2 = 4'd0; bcd_1 = 4'd5; bcd_0 = 4'd0;
    dp_in = 4'b1000; lz_blank = 1'b1;
    repeat (2) @(negedge clk);
    check_pins("held_reset", 4'hF, 7'h7F, 1'b1);
    reset = 1'b1;
    wait_edge(2);  check_pins("lz_f1_d0", 4'hE, 7'h40, 1'b1);
    wait_edge(34); check_pins("lz_d0", 4'hE, 7'h40, 1'b1);
    wait_edge(42); check_pins("lz_d1", 4'hD, 7'h12, 1'b1);
    wait_edge(50); check_pins("lz_d2", 4'hB, 7'h7F, 1'b1);
    wait_edge(58); check_pins("lz_d3_dp", 4'h7, 7'h7F, 1'b0);

    // Illegal code, decimal point, and enable pause during digit 2
    wait_edge(60);
    reset = 1'b0;
    bcd_3 = 4'd8; bcd_2 = 4'hB; bcd_1 = 4'd1; bcd_0 = 4'd0;
    dp_in = 4'b0100; lz_blank = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_edge(42); check_pins("c_d1", 4'hD, 7'h79, 1'b1);
    wait_edge(50); check_pins("c_d2_dash", 4'hB, 7'h3F, 1'b0);
    wait_edge(52); check("pre_pause_an", an, 4'hB);
    enable = 1'b0;
    lit = 0;
    for (int k = 53; k <= 72; k++) begin
      wait_edge(k);
      if (an == 4'hF) lit++;
    end
    check("pause_dark_cycles", lit, 20);
    enable = 1'b1;
    wait_edge(73); check_pins("resume_d2", 4'hB, 7'h3F, 1'b0);
    wait_edge(76); check("resume_tail_an", an, 4'hB);
    wait_edge(77); check_pins("resume_d3_guard", 4'hF, 7'h00, 1'b1);
    wait_edge(78); check_pins("resume_d3", 4'h7, 7'h00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
